// File: rtl/prefetch_buffer_if.sv
// Signal bundle between the prefetch buffer, the instruction memory port and ID.
// The master modport is the prefetch buffer side; slave is its environment.
interface prefetch_buffer_if #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          branch_i;
    logic [31:0]   branch_target_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [31:0]   imem_rdata_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_rdata_o;
    logic [31:0]   instr_pc_o;
    // Internal occupancy exposed for observation.
    logic [CW-1:0] dbg_count_o;
    logic [OW-1:0] dbg_outstanding_o;
    logic [OW-1:0] dbg_discard_o;

    modport master (
        input  branch_i, branch_target_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_rdata_o, instr_pc_o,
        output dbg_count_o, dbg_outstanding_o, dbg_discard_o
    );

    modport slave (
        output branch_i, branch_target_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_rdata_o, instr_pc_o,
        input  dbg_count_o, dbg_outstanding_o, dbg_discard_o
    );
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches, tracks in-flight responses,
// queues {instr, pc} in order and presents them to ID; branch_i redirects and flushes.
module prefetch_buffer #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input logic clk_i,
    input logic rst_i,
    prefetch_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] BOOT_WORD = {BOOT_ADDR[31:2], 2'b00};
    localparam logic [31:0] DEPTH_U   = DEPTH;
    localparam logic [31:0] MAX_OUT_U = MAX_OUTSTANDING;

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;

    logic [31:0] occupancy;
    logic        imem_req;
    logic        granted;
    logic        push;
    logic        pop;

    always_comb begin
        // In-flight requests reserve FIFO room so no response ever has to be dropped.
        occupancy = 32'(count_q) + 32'(outstanding_q);
        imem_req  = !rst_i && !bus.branch_i && (32'(outstanding_q) < MAX_OUT_U)
                    && (occupancy < DEPTH_U);
        granted   = imem_req && bus.imem_gnt_i;
        push      = bus.imem_rvalid_i && (discard_q == '0) && !bus.branch_i;
        pop       = (count_q != '0) && bus.instr_ready_i && !bus.branch_i;

        fetch_addr_d  = fetch_addr_q;
        resp_pc_d     = resp_pc_q;
        data_d        = data_q;
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (bus.branch_i) begin
            fetch_addr_d  = {bus.branch_target_i[31:2], 2'b00};
            resp_pc_d     = {bus.branch_target_i[31:2], 2'b00};
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            // Everything still in flight after this cycle is stale.
            outstanding_d = outstanding_q - OW'(bus.imem_rvalid_i);
            discard_d     = outstanding_q - OW'(bus.imem_rvalid_i);
        end else begin
            if (granted) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            outstanding_d = outstanding_q + OW'(granted) - OW'(bus.imem_rvalid_i);
            if (bus.imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push) begin
                data_d[wr_ptr_q] = bus.imem_rdata_i;
                pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                resp_pc_d        = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr_q  <= BOOT_WORD;
            resp_pc_q     <= BOOT_WORD;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
        end
    end

    assign bus.imem_req_o        = imem_req;
    assign bus.imem_addr_o       = fetch_addr_q;
    assign bus.instr_valid_o     = (count_q != '0);
    assign bus.instr_rdata_o     = data_q[rd_ptr_q];
    assign bus.instr_pc_o        = pc_q[rd_ptr_q];
    assign bus.dbg_count_o       = count_q;
    assign bus.dbg_outstanding_o = outstanding_q;
    assign bus.dbg_discard_o     = discard_q;
endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: a queue-based model of fetch/flush behaviour, a delayed
// in-order memory, directed scenarios and a randomized run.
module tb_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_buffer_if #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) bus ();

  prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  // stimulus controls
  bit          gnt_rand, ready_rand, gnt_val, ready_val, mem_hold, br_now;
  logic [31:0] br_tgt;
  int          delay_max;

  // reference model: fetch pointer, in-flight request addresses with stale flags, FIFO of pcs
  logic [31:0] m_fetch;
  logic [31:0] m_fifo[$];
  logic [31:0] m_out_addr[$];
  bit          m_out_stale[$];

  // memory: addresses it was granted and the cycle each response is due
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due;
  int          cyc;

  logic [31:0] pop_log[$];
  logic [31:0] gnt_log[$];
  int          first_grant_cyc, first_valid_cyc, max_occ;
  bit          last_rv, last_valid, last_ready;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    bit          rv;
    bit          g;
    bit          exp_req;
    bit          exp_valid;
    bit          s;
    logic [31:0] rv_addr;
    logic [31:0] a;
    int          stale_n;
    int          due;

    bus.branch_i        = br_now;
    bus.branch_target_i = br_tgt;
    rv = 1'b0;
    rv_addr = '0;
    if (!mem_hold && mem_due.size() > 0 && mem_due[0] <= cyc) begin
      rv = 1'b1;
      rv_addr = mem_addr.pop_front();
      void'(mem_due.pop_front());
    end
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? instr_of(rv_addr) : $urandom();
    bus.instr_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    g = gnt_rand ? ($urandom_range(0, 2) != 0) : gnt_val;
    bus.imem_gnt_i = g;
    #1;

    exp_req   = !br_now && (m_out_addr.size() < MAXO) && (m_fifo.size() + m_out_addr.size() < DEPTH);
    exp_valid = (m_fifo.size() != 0);
    stale_n = 0;
    foreach (m_out_stale[i]) if (m_out_stale[i]) stale_n++;

    check("imem_req", bus.imem_req_o, exp_req);
    if (exp_req) check("imem_addr", bus.imem_addr_o, m_fetch);
    check("instr_valid", bus.instr_valid_o, exp_valid);
    if (exp_valid) begin
      check("instr_pc", bus.instr_pc_o, m_fifo[0]);
      check("instr_rdata", bus.instr_rdata_o, instr_of(m_fifo[0]));
    end
    check("count", 32'(bus.dbg_count_o), m_fifo.size());
    check("outstanding", 32'(bus.dbg_outstanding_o), m_out_addr.size());
    check("discard", 32'(bus.dbg_discard_o), stale_n);
    check("outstanding_bound", 32'(bus.dbg_outstanding_o <= MAXO), 1);
    if (32'(bus.dbg_count_o) + 32'(bus.dbg_outstanding_o) > max_occ)
      max_occ = 32'(bus.dbg_count_o) + 32'(bus.dbg_outstanding_o);

    last_rv = rv;
    last_valid = bus.instr_valid_o;
    last_ready = bus.instr_ready_i;
    if (bus.instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;

    if (bus.imem_req_o && g) begin
      mem_addr.push_back(bus.imem_addr_o);
      gnt_log.push_back(bus.imem_addr_o);
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      due = cyc + 1 + $urandom_range(0, delay_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_due.push_back(due);
    end

    if (br_now) begin
      m_fifo.delete();
      if (rv && m_out_addr.size() > 0) begin
        void'(m_out_addr.pop_front());
        void'(m_out_stale.pop_front());
      end
      foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
      m_fetch = {br_tgt[31:2], 2'b00};
    end else begin
      if (exp_valid && bus.instr_ready_i) pop_log.push_back(m_fifo.pop_front());
      if (rv && m_out_addr.size() > 0) begin
        a = m_out_addr.pop_front();
        s = m_out_stale.pop_front();
        if (!s) m_fifo.push_back(a);
      end
      if (exp_req && g) begin
        m_out_addr.push_back(m_fetch);
        m_out_stale.push_back(1'b0);
        m_fetch = m_fetch + 32'd4;
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_model();
    m_fifo.delete();
    m_out_addr.delete();
    m_out_stale.delete();
    mem_addr.delete();
    mem_due.delete();
    last_due = 0;
    m_fetch = BOOT;
  endtask

  task automatic seq_mode();
    gnt_rand = 0; ready_rand = 0; gnt_val = 1; ready_val = 1;
    mem_hold = 0; delay_max = 0; br_now = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lp;
    int guard;

    rst = 1'b1;
    bus.branch_i = 0; bus.branch_target_i = '0; bus.imem_gnt_i = 0;
    bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0; bus.instr_ready_i = 0;
    br_tgt = '0; cyc = 0; first_grant_cyc = -1; first_valid_cyc = -1; max_occ = 0;
    seq_mode();
    clear_model();
    @(negedge clk);
    @(negedge clk);

    // reset state
    check("rst_req", bus.imem_req_o, 0);
    check("rst_valid", bus.instr_valid_o, 0);
    check("rst_rdata", bus.instr_rdata_o, 0);
    check("rst_pc", bus.instr_pc_o, 0);
    check("rst_count", 32'(bus.dbg_count_o), 0);
    rst = 1'b0;

    // sequential fetch at full rate
    for (int i = 0; i < 20; i++) step();
    check("seq_first_addr", gnt_log[0], 32'h100);
    check("seq_second_addr", gnt_log[1], 32'h104);
    check("seq_third_addr", gnt_log[2], 32'h108);
    check("seq_first_pc", pop_log[0], 32'h100);
    check("seq_second_pc", pop_log[1], 32'h104);
    check("seq_latency", first_valid_cyc - first_grant_cyc, 2);
    check("seq_throughput", pop_log.size(), 18);

    // backpressure
    lp = pop_log[pop_log.size() - 1];
    ready_val = 0; max_occ = 0;
    for (int i = 0; i < 10; i++) step();
    check("bp_max_occ", max_occ, DEPTH);
    check("bp_full", 32'(bus.dbg_count_o), DEPTH);
    check("bp_req_low", bus.imem_req_o, 0);
    pop_log.delete();
    ready_val = 1;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 4; i++) check("bp_order", pop_log[i], lp + 32'(4 * (i + 1)));

    // branch with two grants unanswered
    mem_hold = 1;
    guard = 0;
    while (bus.dbg_outstanding_o != 2 && guard < 10) begin
      step();
      guard++;
    end
    check("br2_outstanding", 32'(bus.dbg_outstanding_o), 2);
    gnt_log.delete(); pop_log.delete();
    br_now = 1; br_tgt = 32'h2003;
    step();
    br_now = 0;
    check("br2_discard", 32'(bus.dbg_discard_o), 2);
    check("br2_valid_low", bus.instr_valid_o, 0);
    mem_hold = 0;
    for (int i = 0; i < 12; i++) step();
    check("br2_first_addr", gnt_log[0], 32'h2000);
    check("br2_first_pc", pop_log[0], 32'h2000);

    // branch coinciding with rvalid and a pop
    for (int i = 0; i < 6; i++) step();
    pop_log.delete();
    br_now = 1; br_tgt = 32'h3000;
    step();
    br_now = 0;
    check("br4_coincide", {29'd0, last_rv, last_valid, last_ready}, 32'd7);
    check("br4_valid_low", bus.instr_valid_o, 0);
    check("br4_count", 32'(bus.dbg_count_o), 0);
    check("br4_discard", 32'(bus.dbg_discard_o), 0);
    for (int i = 0; i < 6; i++) step();
    check("br4_first_pc", pop_log[0], 32'h3000);

    // randomized delays, grants, ready and branches
    gnt_rand = 1; ready_rand = 1; delay_max = 3;
    for (int i = 0; i < 800; i++) begin
      br_now = ($urandom_range(0, 39) == 0);
      br_tgt = $urandom();
      step();
    end
    br_now = 0;

    // asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", bus.imem_req_o, 0);
    check("arst_valid", bus.instr_valid_o, 0);
    check("arst_count", 32'(bus.dbg_count_o), 0);
    check("arst_outstanding", 32'(bus.dbg_outstanding_o), 0);
    check("arst_discard", 32'(bus.dbg_discard_o), 0);
    check("arst_pc", bus.instr_pc_o, 0);
    clear_model();
    seq_mode();
    gnt_log.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("arst_first_addr", gnt_log[0], BOOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
